// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and constants for the Pong scoring stage:
//               game state encoding, seven-segment patterns and digit
//               box geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Game sequencing states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    PAUSE     = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  // Seven-segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_PATTERN [0:9] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011   // 9
  };

  // Digit box geometry (pixels)
  localparam int DIG_W     = 30;
  localparam int DIG_H     = 50;
  localparam int SEG_T     = 5;
  localparam int DIG_HALF  = 25;  // first row of the lower vertical bars
  localparam int MID_TOP   = 22;  // middle bar, first row
  localparam int MID_BOT   = 27;  // middle bar, last row

endpackage : pong_pkg
`default_nettype wire

// File: rtl/score_digit_painter.sv
`default_nettype none
// ============================================================================
// Module      : score_digit_painter
// Description : Combinational pixel test for one seven-segment digit drawn
//               in a 30x50 box at (ORIGIN_X, ORIGIN_Y).
// Revision    : 1.0 - initial release
// ============================================================================
module score_digit_painter
  import pong_pkg::*;
#(
  parameter int ORIGIN_X = 340,
  parameter int ORIGIN_Y = 20
) (
  input  logic [11:0] xPos,
  input  logic [11:0] yPos,
  input  logic [3:0]  digit,
  output logic        lit
);

  localparam logic [11:0] X0 = 12'(ORIGIN_X);
  localparam logic [11:0] X1 = 12'(ORIGIN_X + DIG_W);
  localparam logic [11:0] Y0 = 12'(ORIGIN_Y);
  localparam logic [11:0] Y1 = 12'(ORIGIN_Y + DIG_H);

  logic [11:0] dx;
  logic [11:0] dy;
  logic        in_box;
  logic [6:0]  pattern;
  logic [6:0]  hit;

  // Decode which segment regions cover the pixel and mask by the digit pattern
  always_comb begin
    dx      = xPos - X0;
    dy      = yPos - Y0;
    in_box  = (xPos >= X0) && (xPos < X1) && (yPos >= Y0) && (yPos < Y1);
    pattern = '0;
    if (digit <= 4'd9) begin
      pattern = SEG_PATTERN[digit];
    end
    hit    = '0;
    hit[6] = (dy < 12'(SEG_T));                                           // a
    hit[5] = (dx >= 12'(DIG_W - SEG_T)) && (dy < 12'(DIG_HALF));          // b
    hit[4] = (dx >= 12'(DIG_W - SEG_T)) && (dy >= 12'(DIG_HALF));         // c
    hit[3] = (dy >= 12'(DIG_H - SEG_T));                                  // d
    hit[2] = (dx < 12'(SEG_T)) && (dy >= 12'(DIG_HALF));                  // e
    hit[1] = (dx < 12'(SEG_T)) && (dy < 12'(DIG_HALF));                   // f
    hit[0] = (dy >= 12'(MID_TOP)) && (dy <= 12'(MID_BOT));                // g
    lit    = in_box && (|(hit & pattern));
  end

endmodule : score_digit_painter
`default_nettype wire

// File: rtl/pong_score_fsm.sv
`default_nettype none
// ============================================================================
// Module      : pong_score_fsm
// Description : Pong game-state and scoring stage. Detects edge misses,
//               keeps scores, sequences serve/pause/game-over, holds the
//               ball and paints both scores as seven-segment digits.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_score_fsm
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int LEFT_EDGE   = 0,
  parameter int RIGHT_EDGE  = 799,
  parameter int PAUSE_TICKS = 120,
  parameter int LDIG_X      = 340,
  parameter int RDIG_X      = 430,
  parameter int DIG_Y       = 20
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        tick,
  input  logic        serve,
  input  logic [10:0] ballLeft,
  input  logic [10:0] ballRight,
  input  logic [11:0] xPos,
  input  logic [11:0] yPos,
  output logic        ballHold,
  output logic [3:0]  scoreLeft,
  output logic [3:0]  scoreRight,
  output logic        gameOver,
  output logic        winner,
  output logic        drawScore
);

  localparam int CNT_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

  state_e             state_q, state_d;
  logic [3:0]         score_l_q, score_l_d;
  logic [3:0]         score_r_q, score_r_d;
  logic               winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_q, hold_d;
  logic               over_q, over_d;
  logic               serve_q;
  logic               draw_q;
  logic               serve_edge;
  logic               lit_l, lit_r;

  // Next-state, scoring and registered-output decode
  always_comb begin
    state_d    = state_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    serve_edge = serve & ~serve_q;

    case (state_q)
      IDLE: begin
        if (serve_edge) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          // Left miss wins the tie when both edges are touched
          if (ballLeft <= 11'(LEFT_EDGE)) begin
            score_r_d = score_r_q + 4'd1;
            if (score_r_d == 4'(WIN_SCORE)) begin
              state_d  = GAME_OVER;
              winner_d = 1'b1;
            end else begin
              state_d = PAUSE;
              cnt_d   = '0;
            end
          end else if (ballRight >= 11'(RIGHT_EDGE)) begin
            score_l_d = score_l_q + 4'd1;
            if (score_l_d == 4'(WIN_SCORE)) begin
              state_d  = GAME_OVER;
              winner_d = 1'b0;
            end else begin
              state_d = PAUSE;
              cnt_d   = '0;
            end
          end
        end
      end
      PAUSE: begin
        if (tick) begin
          if (cnt_q == CNT_W'(PAUSE_TICKS - 1)) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (serve_edge) begin
          state_d   = IDLE;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Hold rises on the very edge that leaves PLAY
    hold_d = (state_d != PLAY);
    over_d = (state_d == GAME_OVER);
  end

  // State, score and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= 1'b1;
      over_q    <= 1'b0;
      serve_q   <= 1'b0;
      draw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      over_q    <= over_d;
      serve_q   <= serve;
      draw_q    <= lit_l | lit_r;
    end
  end

  score_digit_painter #(
    .ORIGIN_X (LDIG_X),
    .ORIGIN_Y (DIG_Y)
  ) u_left_digit (
    .xPos  (xPos),
    .yPos  (yPos),
    .digit (score_l_q),
    .lit   (lit_l)
  );

  score_digit_painter #(
    .ORIGIN_X (RDIG_X),
    .ORIGIN_Y (DIG_Y)
  ) u_right_digit (
    .xPos  (xPos),
    .yPos  (yPos),
    .digit (score_r_q),
    .lit   (lit_r)
  );

  assign ballHold   = hold_q;
  assign scoreLeft  = score_l_q;
  assign scoreRight = score_r_q;
  assign gameOver   = over_q;
  assign winner     = winner_q;
  assign drawScore  = draw_q;

endmodule : pong_score_fsm
`default_nettype wire
